// File: rtl/alu_pkg.sv
// Shared definitions for the ALU time-sharing arbiter: ALU control codes and
// the arbiter state encoding.
package alu_pkg;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_AND = 3'b010;
  localparam alu_ctrl_t ALU_OR  = 3'b011;
  localparam alu_ctrl_t ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational grant picker: first asserted request at or after the start
// pointer, wrapping modulo NUM_REQ. A zero pointer gives fixed priority.
module alu_rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    idx,
  output logic               found
);

  logic [IDXW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDXW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    gnt = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU between NUM_REQ requesters with an
// IDLE/EXEC/RESP sequence. Define ALU_ARB_RR_EN for round-robin arbitration;
// otherwise the lowest requester index wins.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][2:0]         req_ctrl,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_op1,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_op2,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [WIDTH-1:0]                rsp_data,
  output logic                            rsp_eq,
  output alu_ctrl_t                       alu_ctrl,
  output logic [WIDTH-1:0]                alu_op1,
  output logic [WIDTH-1:0]                alu_op2,
  input  logic [WIDTH-1:0]                alu_out,
  input  logic                            alu_eq
);

  localparam int IDXW = $clog2(NUM_REQ);

  arb_state_t          state;
  logic [IDXW-1:0]     owner;
  logic [IDXW-1:0]     ptr;
  logic [IDXW-1:0]     gidx;
  logic [NUM_REQ-1:0]  gnt;
  logic                gfound;

  alu_rr_grant #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_grant (
    .req   (req_valid),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gidx),
    .found (gfound)
  );

  // Ready is offered only while idle, so at most one accept per transaction.
  assign req_ready = (state == ST_IDLE && !rst) ? gnt : '0;

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == ST_IDLE && gfound) begin
      ptr <= (gidx == IDXW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      alu_ctrl  <= ALU_ADD;
      alu_op1   <= '0;
      alu_op2   <= '0;
      rsp_data  <= '0;
      rsp_eq    <= 1'b0;
      rsp_valid <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gfound) begin
            alu_ctrl <= req_ctrl[gidx];
            alu_op1  <= req_op1[gidx];
            alu_op2  <= req_op2[gidx];
            owner    <= gidx;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_out;
          rsp_eq    <= alu_eq;
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized
// traffic against a transaction-level reference model and a stand-in ALU.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][2:0]  req_ctrl;
  logic [N-1:0][W-1:0] req_op1, req_op2;
  logic [W-1:0]       rsp_data, alu_op1, alu_op2, alu_out;
  logic               rsp_eq, alu_eq;
  alu_ctrl_t          alu_ctrl;

  always #5 clk = ~clk;

  alu_share_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_eq(rsp_eq),
    .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out), .alu_eq(alu_eq)
  );

  function automatic logic [W-1:0] ref_alu(alu_ctrl_t c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return (a < b) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // Stand-in for the combinational ALU the arbiter drives.
  always_comb begin
    alu_out = ref_alu(alu_ctrl, alu_op1, alu_op2);
    alu_eq  = (alu_op1 == alu_op2);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Staged inputs, applied by tick() on the falling edge.
  logic [N-1:0]  s_valid, s_rdy;
  alu_ctrl_t     s_ctrl [N];
  logic [W-1:0]  s_op1 [N];
  logic [W-1:0]  s_op2 [N];

  // Reference model: one outstanding transaction, its age in cycles since accept.
  bit            busy;
  int            age, owner, rr_ptr;
  logic [W-1:0]  exp_data, last_op1, last_op2;
  alu_ctrl_t     last_ctrl;
  logic          exp_eq;
  logic [W-1:0]  obs_data;
  logic          obs_eq;
  int            grant_log[$];

  function automatic int exp_grant(logic [N-1:0] v, int start);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = v >> ((start + k) % N);
      if (sh[0]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    busy = 0; age = 0; owner = 0; rr_ptr = 0;
    last_op1 = '0; last_op2 = '0; last_ctrl = ALU_ADD;
  endtask

  task automatic tick();
    logic [N-1:0] exp_v, exp_r, sh;
    int g;
    @(negedge clk);
    exp_v = (busy && age >= 2) ? (N'(1) << owner) : '0;
    check("rsp_valid", rsp_valid, exp_v);
    if (exp_v != '0) begin
      check("rsp_data", rsp_data, exp_data);
      check("rsp_eq", rsp_eq, exp_eq);
    end
    check("alu_ctrl", alu_ctrl, last_ctrl);
    check("alu_op1", alu_op1, last_op1);
    check("alu_op2", alu_op2, last_op2);
    req_valid = s_valid;
    rsp_ready = s_rdy;
    for (int i = 0; i < N; i++) begin
      req_ctrl[i] = s_ctrl[i];
      req_op1[i]  = s_op1[i];
      req_op2[i]  = s_op2[i];
    end
    #1;
    g = busy ? -1 : exp_grant(s_valid, rr_ptr);
    exp_r = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", req_ready, exp_r);
    for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    if (g >= 0) begin
      busy = 1; age = 1; owner = g;
      last_ctrl = s_ctrl[g]; last_op1 = s_op1[g]; last_op2 = s_op2[g];
      exp_data  = ref_alu(last_ctrl, last_op1, last_op2);
      exp_eq    = (last_op1 == last_op2);
`ifdef ALU_ARB_RR_EN
      rr_ptr = (g + 1) % N;
`endif
    end else if (busy) begin
      sh = s_rdy >> owner;
      if (age >= 2 && sh[0]) begin
        busy = 0;
        obs_data = rsp_data;
        obs_eq   = rsp_eq;
      end else begin
        age++;
      end
    end
  endtask

  task automatic set_req(input int r, input alu_ctrl_t c, input logic [W-1:0] a, input logic [W-1:0] b);
    s_valid[r] = 1'b1;
    s_ctrl[r] = c; s_op1[r] = a; s_op2[r] = b;
  endtask

  task automatic run_one(input int r, input alu_ctrl_t c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int stall);
    s_valid = '0; s_rdy = '0;
    set_req(r, c, a, b);
    tick();
    s_valid = '0;
    repeat (1 + stall) tick();
    s_rdy[r] = 1'b1;
    tick();
    s_rdy = '0;
    tick();
  endtask

  int exp_seq [4];

  initial begin
    rst = 1'b1;
    s_valid = '0; s_rdy = '0;
    for (int i = 0; i < N; i++) begin s_ctrl[i] = ALU_ADD; s_op1[i] = '0; s_op2[i] = '0; end
    req_valid = '0; rsp_ready = '0; req_ctrl = '0; req_op1 = '0; req_op2 = '0;
    model_reset();
    obs_data = '0; obs_eq = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_eq", rsp_eq, 1'b0);
    check("rst_alu_ctrl", alu_ctrl, 3'b000);
    rst = 1'b0;

    run_one(0, ALU_ADD, 32'd5, 32'd7, 0);
    check("add_5_7_data", obs_data, 32'd12);
    check("add_5_7_eq", obs_eq, 1'b0);
    run_one(1, ALU_SUB, 32'h10, 32'h10, 0);
    check("sub_eq_data", obs_data, 32'd0);
    check("sub_eq_flag", obs_eq, 1'b1);
    run_one(1, ALU_SLT, 32'd3, 32'd9, 1);
    check("slt_3_9", obs_data, 32'd1);
    run_one(0, 3'b111, 32'hFFFF_FFFF, 32'd1, 0);
    check("unsup_data", obs_data, 32'd0);
    check("unsup_eq", obs_eq, 1'b0);

    // Backpressure: owner 0 stalls 5 cycles while requester 1 waits; non-owner ready ignored.
    grant_log.delete();
    s_valid = '0; s_rdy = '0;
    set_req(0, ALU_OR, 32'hF0, 32'h0F);
    tick();
    s_valid = '0;
    set_req(1, ALU_AND, 32'hFF, 32'h3C);
    s_rdy = 2'b10;
    repeat (6) tick();
    s_rdy = 2'b01;
    tick();
    check("bp_data", obs_data, 32'hFF);
    s_rdy = '0;
    tick();
    s_valid = '0;
    tick();
    s_rdy = 2'b10;
    tick();
    s_rdy = '0;
    tick();
    check("bp_and_data", obs_data, 32'h3C);
    check("bp_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("bp_grant0", grant_log[0], 0);
      check("bp_grant1", grant_log[1], 1);
    end

    // Reset asserted while the transaction is in EXEC.
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    tick();
    s_valid = '0;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, '0);
    check("mid_rst_alu_op1", alu_op1, '0);
    check("mid_rst_alu_op2", alu_op2, '0);
    check("mid_rst_rsp_data", rsp_data, '0);
    check("mid_rst_req_ready", req_ready, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // Contention: both requesters valid continuously, consumers always ready.
    grant_log.delete();
    s_rdy = 2'b11;
    set_req(0, ALU_ADD, 32'd100, 32'd1);
    set_req(1, ALU_SUB, 32'd100, 32'd1);
    for (int c = 0; c < 40 && grant_log.size() < 4; c++) tick();
    s_valid = '0;
    repeat (4) tick();
    s_rdy = '0;
`ifdef ALU_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    check("cont_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) check($sformatf("cont_grant%0d", k), grant_log[k], exp_seq[k]);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      s_valid = N'($urandom_range(0, (1 << N) - 1));
      s_rdy   = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        s_ctrl[i] = alu_ctrl_t'($urandom_range(0, 7));
        s_op1[i]  = $urandom;
        s_op2[i]  = ($urandom_range(0, 3) == 0) ? s_op1[i] : $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Sequencing arbiter that time-shares the single-cycle ALU between NUM_REQ requesters (e.g. the main datapath and an address/branch helper unit). It grants one request at a time, drives the ALU's control and operand inputs from registers, captures the ALU result and equality flag, and returns them to the granted requester over a valid/ready response handshake. It sits between the requesters and the ALU instance; the ALU itself stays purely combinational.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- WIDTH, 32, operand/result width

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  request pending per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_ctrl  in  NUM_REQ×3  ALU control code per requester
- req_op1  in  NUM_REQ×WIDTH  operand 1 per requester
- req_op2  in  NUM_REQ×WIDTH  operand 2 per requester
- rsp_valid  out  NUM_REQ  result valid, one-hot to owning requester
- rsp_ready  in  NUM_REQ  requester consumes result
- rsp_data  out  WIDTH  captured ALU result (shared bus)
- rsp_eq  out  1  captured ALU equality flag
- alu_ctrl  out  3  to ALU control input
- alu_op1  out  WIDTH  to ALU operand 1
- alu_op2  out  WIDTH  to ALU operand 2
- alu_out  in  WIDTH  from ALU result
- alu_eq  in  1  from ALU equality flag

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant = arbitration over req_valid; req_ready[grant]=1 combinationally, all other req_ready=0. Nothing valid -> stay IDLE, req_ready=0.
- Accept (req_valid&req_ready): latch req_ctrl/op1/op2 of grant into alu_ctrl/alu_op1/alu_op2 registers, latch owner index, go EXEC.
- EXEC: ALU evaluates registered inputs; capture alu_out -> rsp_data, alu_eq -> rsp_eq; go RESP.
- RESP: rsp_valid[owner]=1; rsp_data/rsp_eq held stable. On rsp_ready[owner] go IDLE. rsp_ready of non-owners ignored.
- ALU codes passed through unmodified: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (unsigned compare), others give result 0. Arbiter performs no arithmetic; widths pass straight through.
- Requester may drop req_valid before acceptance without penalty; request fields need only be stable in the accept cycle.
- Operand registers hold last accepted values outside EXEC (no toggling when idle).

## Timing
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_eq 0, alu_ctrl 000, alu_op1 0, alu_op2 0, priority pointer 0.
- Accept at edge t -> EXEC during cycle t+1 -> rsp_valid high from cycle t+2.
- Minimum 3 cycles per transaction (IDLE, EXEC, RESP with immediate rsp_ready); no overlap of transactions.
- rsp_valid stays high indefinitely until rsp_ready; stall in RESP blocks all requesters.
- Reset asserted mid-transaction: all state returns to reset values immediately; in-flight result is discarded, no rsp_valid.
- Simultaneous requests in IDLE: exactly one granted per the configured policy.

## Configuration
- ALU_ARB_RR_EN defined: round-robin. Pointer updates on each accept to (grant+1) mod NUM_REQ; search starts at pointer. Any requester holding req_valid is granted within NUM_REQ transactions.
- ALU_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- alu_pkg: ALU control code constants (ADD/SUB/AND/OR/SLT), alu_ctrl_t (3-bit), arbiter state enum arb_state_t.
- One sub-module: alu_rr_grant — combinational grant from request vector and start pointer, one-hot output plus index; pointer tied to 0 when ALU_ARB_RR_EN undefined.

## Test plan
- Reset: rst high mid-EXEC -> all outputs at reset values next cycle; no rsp_valid after release.
- Single request: req 0 ADD 5+7 accepted at t -> rsp_valid[0] at t+2, rsp_data=12, rsp_eq=0.
- SUB equality: req 1 SUB 0x10-0x10 -> rsp_data=0, rsp_eq=1; SLT 3,9 -> rsp_data=1.
- Contention, RR enabled: both valid continuously, 4 transactions -> grants 0,1,0,1; fixed priority -> 0,0,0,0.
- Backpressure: rsp_ready[0] low 5 cycles -> rsp_valid[0] and rsp_data held stable, req_ready all 0, req 1 waiting not accepted until release.
- Unsupported code 111 with ops 0xFFFFFFFF,1 -> rsp_data=0, rsp_eq=0, transaction completes normally.
